imem_loadable: RTL and testbench

Parametrised, run-time loadable instruction memory for the microprocessor fetch stage. It replaces the fixed program ROM with a writable store, filled word by word over a valid/ready load port. It also gives a registered fetch path with a validity flag, so the control unit stalls while a program is being loaded. Addresses beyond the loaded program length return a configurable fill word.

---
 rtl/imem_loadable.sv | 104 ++++++++++
 tb/tb_imem_loadable.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: valid/ready load port fills the store,
// registered fetch path returns FILL_WORD beyond the loaded program or while loading.
module imem_loadable #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 64,
  parameter int unsigned      ADDR_W    = 8,
  parameter logic [WIDTH-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read_Address,
  output logic [WIDTH-1:0]  Instruction,
  output logic              Fetch_Valid,
  input  logic              Load_Start,
  input  logic [WIDTH-1:0]  Load_Data,
  input  logic              Load_Valid,
  input  logic              Load_Last,
  output logic              Load_Ready,
  output logic              Load_Done,
  output logic              Load_Error,
  output logic [ADDR_W:0]   Program_Length
);

  localparam int unsigned   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  typedef enum logic {RUN, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr;
  logic              load_err_q;
  logic              load_done_q;
  logic [WIDTH-1:0]  instr_q;
  logic              fetch_valid_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              beat;
  logic              has_room;
  logic              rd_hit;

  // A Load_Start in the same cycle as a valid word takes priority and drops it.
  assign beat     = (state_q == LOAD) && Load_Valid && !Load_Start;
  assign has_room = (wr_ptr < DEPTH_LEN);
  assign rd_hit   = ({1'b0, Read_Address} < wr_ptr);

  always_comb begin
    state_d = state_q;
    if (Load_Start) begin
      state_d = LOAD;
    end else if (beat && Load_Last) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      wr_ptr      <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= beat && Load_Last;
      if (Load_Start) begin
        wr_ptr     <= '0;
        load_err_q <= 1'b0;
      end else if (beat) begin
        if (has_room) begin
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          load_err_q <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; Program_Length gates every read.
  always_ff @(posedge clk) begin
    if (beat && has_room) begin
      mem[wr_ptr[IDX_W-1:0]] <= Load_Data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q       <= FILL_WORD;
      fetch_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      instr_q       <= rd_hit ? mem[Read_Address[IDX_W-1:0]] : FILL_WORD;
      fetch_valid_q <= 1'b1;
    end else begin
      instr_q       <= FILL_WORD;
      fetch_valid_q <= 1'b0;
    end
  end

  assign Instruction    = instr_q;
  assign Fetch_Valid    = fetch_valid_q;
  assign Load_Ready     = (state_q == LOAD);
  assign Load_Done      = load_done_q;
  assign Load_Error     = load_err_q;
  assign Program_Length = wr_ptr;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed vector bench for imem_loadable (DEPTH = 4 so overflow is reachable).
module tb_imem_loadable;

  logic       clk;
  logic       reset_n;
  logic [7:0] Read_Address;
  logic [7:0] Instruction;
  logic       Fetch_Valid;
  logic       Load_Start;
  logic [7:0] Load_Data;
  logic       Load_Valid;
  logic       Load_Last;
  logic       Load_Ready;
  logic       Load_Done;
  logic       Load_Error;
  logic [8:0] Program_Length;

  int unsigned applied;
  int unsigned miscompares;

  imem_loadable #(
    .WIDTH    (8),
    .DEPTH    (4),
    .ADDR_W   (8),
    .FILL_WORD(8'h00)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .Read_Address  (Read_Address),
    .Instruction   (Instruction),
    .Fetch_Valid   (Fetch_Valid),
    .Load_Start    (Load_Start),
    .Load_Data     (Load_Data),
    .Load_Valid    (Load_Valid),
    .Load_Last     (Load_Last),
    .Load_Ready    (Load_Ready),
    .Load_Done     (Load_Done),
    .Load_Error    (Load_Error),
    .Program_Length(Program_Length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         st, v, lst;
    logic [7:0] d, a;
    logic [7:0] ei;
    bit         efv, erdy, edone, eerr;
    logic [8:0] epl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string tag, input bit st, input bit v, input bit lst,
                     input logic [7:0] d, input logic [7:0] a, input logic [7:0] ei,
                     input bit efv, input bit erdy, input bit edone, input bit eerr,
                     input logic [8:0] epl);
    vec_t x;
    x.tag = tag; x.st = st; x.v = v; x.lst = lst; x.d = d; x.a = a;
    x.ei = ei; x.efv = efv; x.erdy = erdy; x.edone = edone; x.eerr = eerr; x.epl = epl;
    vq.push_back(x);
  endtask

  task automatic check(input string tag, input logic [7:0] ei, input bit efv, input bit erdy,
                       input bit edone, input bit eerr, input logic [8:0] epl);
    applied++;
    if (Instruction !== ei || Fetch_Valid !== efv || Load_Ready !== erdy ||
        Load_Done !== edone || Load_Error !== eerr || Program_Length !== epl) begin
      miscompares++;
      $display("FAIL %s: got instr=%h fv=%b rdy=%b done=%b err=%b len=%0d, want instr=%h fv=%b rdy=%b done=%b err=%b len=%0d",
               tag, Instruction, Fetch_Valid, Load_Ready, Load_Done, Load_Error, Program_Length,
               ei, efv, erdy, edone, eerr, epl);
    end
  endtask

  task automatic drive(input bit st, input bit v, input bit lst, input logic [7:0] d,
                       input logic [7:0] a);
    Load_Start = st; Load_Valid = v; Load_Last = lst; Load_Data = d; Read_Address = a;
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;

    // idle after reset: fill word, fetch enabled, nothing loaded
    add("rst_fetch0", 0,0,0, 8'h00, 8'd0, 8'h00, 1,0,0,0, 9'd0);
    add("rst_fetch1", 0,0,0, 8'h00, 8'd1, 8'h00, 1,0,0,0, 9'd0);
    add("rst_fetch2", 0,0,0, 8'h00, 8'd2, 8'h00, 1,0,0,0, 9'd0);
    add("rst_fetch3", 0,0,0, 8'h00, 8'd3, 8'h00, 1,0,0,0, 9'd0);
    // four-word load
    add("ld4_start",  1,0,0, 8'h00, 8'd7, 8'h00, 1,1,0,0, 9'd0);
    add("ld4_w0",     0,1,0, 8'h50, 8'd7, 8'h00, 0,1,0,0, 9'd1);
    add("ld4_w1",     0,1,0, 8'h59, 8'd7, 8'h00, 0,1,0,0, 9'd2);
    add("ld4_w2",     0,1,0, 8'h2A, 8'd7, 8'h00, 0,1,0,0, 9'd3);
    add("ld4_last",   0,1,1, 8'hC2, 8'd0, 8'h00, 0,0,1,0, 9'd4);
    add("ld4_rd0",    0,0,0, 8'h00, 8'd0, 8'h50, 1,0,0,0, 9'd4);
    add("ld4_rd1",    0,0,0, 8'h00, 8'd1, 8'h59, 1,0,0,0, 9'd4);
    add("ld4_rd2",    0,0,0, 8'h00, 8'd2, 8'h2A, 1,0,0,0, 9'd4);
    add("ld4_rd3",    0,0,0, 8'h00, 8'd3, 8'hC2, 1,0,0,0, 9'd4);
    add("ld4_rd4",    0,0,0, 8'h00, 8'd4, 8'h00, 1,0,0,0, 9'd4);
    add("ld4_rd5",    0,0,0, 8'h00, 8'd5, 8'h00, 1,0,0,0, 9'd4);
    // valid toggling: only valid cycles accepted
    add("tog_start",  1,0,0, 8'h00, 8'd7, 8'h00, 1,1,0,0, 9'd0);
    add("tog_v1",     0,1,0, 8'hA1, 8'd0, 8'h00, 0,1,0,0, 9'd1);
    add("tog_v0a",    0,0,0, 8'hFF, 8'd0, 8'h00, 0,1,0,0, 9'd1);
    add("tog_v1b",    0,1,0, 8'hB2, 8'd0, 8'h00, 0,1,0,0, 9'd2);
    add("tog_v0b",    0,0,0, 8'hEE, 8'd0, 8'h00, 0,1,0,0, 9'd2);
    add("tog_last",   0,1,1, 8'hC3, 8'd0, 8'h00, 0,0,1,0, 9'd3);
    add("tog_rd0",    0,0,0, 8'h00, 8'd0, 8'hA1, 1,0,0,0, 9'd3);
    add("tog_rd1",    0,0,0, 8'h00, 8'd1, 8'hB2, 1,0,0,0, 9'd3);
    add("tog_rd2",    0,0,0, 8'h00, 8'd2, 8'hC3, 1,0,0,0, 9'd3);
    add("tog_rd3",    0,0,0, 8'h00, 8'd3, 8'h00, 1,0,0,0, 9'd3);
    // overflow: six words into DEPTH=4
    add("ovf_start",  1,0,0, 8'h00, 8'd7, 8'h00, 1,1,0,0, 9'd0);
    add("ovf_w0",     0,1,0, 8'h01, 8'd0, 8'h00, 0,1,0,0, 9'd1);
    add("ovf_w1",     0,1,0, 8'h02, 8'd0, 8'h00, 0,1,0,0, 9'd2);
    add("ovf_w2",     0,1,0, 8'h03, 8'd0, 8'h00, 0,1,0,0, 9'd3);
    add("ovf_w3",     0,1,0, 8'h04, 8'd0, 8'h00, 0,1,0,0, 9'd4);
    add("ovf_w4",     0,1,0, 8'h05, 8'd0, 8'h00, 0,1,0,1, 9'd4);
    add("ovf_last",   0,1,1, 8'h06, 8'd0, 8'h00, 0,0,1,1, 9'd4);
    add("ovf_rd0",    0,0,0, 8'h00, 8'd0, 8'h01, 1,0,0,1, 9'd4);
    add("ovf_rd1",    0,0,0, 8'h00, 8'd1, 8'h02, 1,0,0,1, 9'd4);
    add("ovf_rd2",    0,0,0, 8'h00, 8'd2, 8'h03, 1,0,0,1, 9'd4);
    add("ovf_rd3",    0,0,0, 8'h00, 8'd3, 8'h04, 1,0,0,1, 9'd4);
    add("ovf_rd4",    0,0,0, 8'h00, 8'd4, 8'h00, 1,0,0,1, 9'd4);
    // restart mid-load, Start+Valid collision drops the word
    add("rs_start",   1,0,0, 8'h00, 8'd7, 8'h00, 1,1,0,0, 9'd0);
    add("rs_w0",      0,1,0, 8'hA0, 8'd0, 8'h00, 0,1,0,0, 9'd1);
    add("rs_w1",      0,1,0, 8'hA1, 8'd0, 8'h00, 0,1,0,0, 9'd2);
    add("rs_restart", 1,1,0, 8'hDD, 8'd0, 8'h00, 0,1,0,0, 9'd0);
    add("rs_n0",      0,1,0, 8'hB0, 8'd0, 8'h00, 0,1,0,0, 9'd1);
    add("rs_n1",      0,1,0, 8'hB1, 8'd0, 8'h00, 0,1,0,0, 9'd2);
    add("rs_last",    0,1,1, 8'hB2, 8'd0, 8'h00, 0,0,1,0, 9'd3);
    add("rs_rd0",     0,0,0, 8'h00, 8'd0, 8'hB0, 1,0,0,0, 9'd3);
    add("rs_rd1",     0,0,0, 8'h00, 8'd1, 8'hB1, 1,0,0,0, 9'd3);
    add("rs_rd2",     0,0,0, 8'h00, 8'd2, 8'hB2, 1,0,0,0, 9'd3);
    add("rs_rd3_old", 0,0,0, 8'h00, 8'd3, 8'h00, 1,0,0,0, 9'd3);

    drive(0, 0, 0, 8'h00, 8'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_vals", 8'h00, 0, 0, 0, 0, 9'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].st, vq[i].v, vq[i].lst, vq[i].d, vq[i].a);
      @(posedge clk);
      #1 check(vq[i].tag, vq[i].ei, vq[i].efv, vq[i].erdy, vq[i].edone, vq[i].eerr, vq[i].epl);
    end

    // asynchronous reset in the middle of a load
    @(negedge clk) drive(1, 0, 0, 8'h00, 8'd0);
    @(posedge clk);
    @(negedge clk) drive(0, 1, 0, 8'hE0, 8'd0);
    @(posedge clk);
    @(negedge clk) drive(0, 1, 0, 8'hE1, 8'd0);
    @(posedge clk);
    #1 check("ar_partial", 8'h00, 0, 1, 0, 0, 9'd2);
    #2 reset_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'd0);
    #1 check("ar_async", 8'h00, 0, 0, 0, 0, 9'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk) drive(0, 0, 0, 8'h00, 8'd0);
    @(posedge clk);
    #1 check("ar_fetch0", 8'h00, 1, 0, 0, 0, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
